lc3_mem_ctrl: RTL and testbench

Memory-side sequencer between the LC-3 datapath MAR/MDR registers and an external single-port memory bus. It produces the `memRDY` status that the control FSM polls in its fetch, load, store and interrupt states, and starts a read on every MAR load. It also performs writes on `memWE` and returns read data to the MDR input mux. It supports one outstanding access, with a req/ack handshake on the external side.

---
 rtl/lc3_mem_ctrl.sv | 143 ++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory sequencer: turns MAR loads and memWE into single req/ack bus accesses
// and reports memRDY. Optional access timeout is built when LC3_MEM_TIMEOUT_EN is defined.
module lc3_mem_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ldMAR,
  input  logic [15:0] mar,
  input  logic        memWE,
  input  logic [15:0] wdata,
  output logic        memRDY,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        bus_err
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("lc3_mem_ctrl: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RD, S_WR} state_t;

  state_t      state, state_n;
  logic        pend_ld, pend_ld_n;
  logic [15:0] addr_q, wdata_q;
  logic        busy, expire, done;
  logic        rdy_n, req_n, we_n;

  assign busy = (state == S_RD) || (state == S_WR);

`ifdef LC3_MEM_TIMEOUT_EN
  logic [7:0] cnt;

  // An ack in the expiry cycle wins: the access completes normally.
  assign expire = busy && !mem_ack && (cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst)       cnt <= '0;
    else if (!busy) cnt <= '0;
    else if (!mem_ack) cnt <= cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst)        bus_err <= 1'b0;
    else if (expire) bus_err <= 1'b1;
  end
`else
  assign expire  = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign done = busy && (mem_ack || expire);

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      pend_ld <= 1'b0;
    end else begin
      state   <= state_n;
      pend_ld <= pend_ld_n;
    end
  end

  // next state; a load arriving in the completion cycle still chains a read
  always_comb begin
    state_n   = state;
    pend_ld_n = pend_ld;
    unique case (state)
      S_IDLE: begin
        if (memWE) begin
          state_n   = S_WR;
          pend_ld_n = ldMAR;
        end else if (ldMAR) begin
          state_n = S_PEND;
        end
      end
      S_PEND: begin
        state_n = S_RD;
        if (ldMAR) pend_ld_n = 1'b1;
      end
      S_RD, S_WR: begin
        if (ldMAR) pend_ld_n = 1'b1;
        if (done) begin
          if (pend_ld || ldMAR) begin
            state_n   = S_PEND;
            pend_ld_n = 1'b0;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // outputs decoded from the next state so they leave the flops aligned with state
  always_comb begin
    rdy_n = (state_n == S_IDLE);
    req_n = (state_n == S_RD) || (state_n == S_WR);
    we_n  = (state_n == S_WR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      memRDY  <= 1'b1;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      memRDY  <= rdy_n;
      mem_req <= req_n;
      mem_we  <= we_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      if ((state == S_IDLE && memWE) || state == S_PEND) addr_q <= mar;
      if (state == S_IDLE && memWE) wdata_q <= wdata;
    end
  end

  // write completion mirrors the stored data so rdata tracks the written location
  always_ff @(posedge clk) begin
    if (!rst)                              rdata <= '0;
    else if (state == S_RD && mem_ack)     rdata <= mem_rdata;
    else if (state == S_RD && expire)      rdata <= '0;
    else if (state == S_WR && mem_ack)     rdata <= wdata_q;
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Randomized bench for lc3_mem_ctrl: the bench plays the memory and keeps a
// word-level memory model; every access is checked against the documented cycle timing.
module tb_lc3_mem_ctrl;
  logic        clk = 1'b0, rst = 1'b0;
  logic        ldMAR = 1'b0, memWE = 1'b0, mem_ack = 1'b0;
  logic [15:0] mar = '0, wdata = '0, mem_rdata = '0;
  logic        memRDY, mem_req, mem_we, bus_err;
  logic [15:0] rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  lc3_mem_ctrl #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .ldMAR(ldMAR), .mar(mar), .memWE(memWE), .wdata(wdata),
    .memRDY(memRDY), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .bus_err(bus_err)
  );

  int n_chk = 0, n_err = 0;
  logic [15:0] mem [logic [15:0]];
  logic [15:0] cur_mar = '0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rd_mem(input logic [15:0] a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // advance one cycle; one-cycle pulses drop, bus read data is garbage unless acked
  task automatic cyc();
    @(posedge clk); #1;
    ldMAR = 1'b0; memWE = 1'b0; mem_ack = 1'b0;
    mem_rdata = 16'($urandom);
  endtask

  // read phase from RD entry: k wait cycles then ack
  task automatic bus_read(input string tag, input logic [15:0] a, input int k);
    for (int i = 0; i <= k; i++) begin
      cyc();
      if (i == k) begin mem_ack = 1'b1; mem_rdata = rd_mem(a); end
      @(negedge clk);
      chk({tag, "_req"}, mem_req, 1'b1);
      chk({tag, "_we"}, mem_we, 1'b0);
      chk({tag, "_addr"}, mem_addr, a);
    end
  endtask

  task automatic do_read(input logic [15:0] a, input int k);
    cyc(); ldMAR = 1'b1;
    @(negedge clk); chk("rd_idle_rdy", memRDY, 1'b1);
    cyc(); mar = a; cur_mar = a;
    @(negedge clk);
    chk("rd_pend_rdy", memRDY, 1'b0);
    chk("rd_pend_req", mem_req, 1'b0);
    bus_read("rd", a, k);
    cyc(); @(negedge clk);
    chk("rd_done_rdy", memRDY, 1'b1);
    chk("rd_done_req", mem_req, 1'b0);
    chk("rd_data", rdata, mem[a]);
  endtask

  // write to current MAR; with_ld also loads MAR=b in the same cycle
  task automatic do_write(input logic [15:0] d, input int k, input bit with_ld,
                          input logic [15:0] b, input int k2);
    logic [15:0] a;
    a = cur_mar;
    cyc(); memWE = 1'b1; wdata = d; ldMAR = with_ld;
    @(negedge clk); chk("wr_idle_rdy", memRDY, 1'b1);
    for (int i = 0; i <= k; i++) begin
      cyc();
      if (i == 0 && with_ld) begin mar = b; cur_mar = b; end
      if (i == k) mem_ack = 1'b1;
      @(negedge clk);
      chk("wr_req", mem_req, 1'b1);
      chk("wr_we", mem_we, 1'b1);
      chk("wr_addr", mem_addr, a);
      chk("wr_wdata", mem_wdata, d);
      chk("wr_rdy", memRDY, 1'b0);
    end
    mem[a] = d;
    cyc(); @(negedge clk);
    chk("wr_done_req", mem_req, 1'b0);
    chk("wr_done_rdy", memRDY, !with_ld);
    chk("wr_rdata", rdata, d);
    if (with_ld) begin
      bus_read("wrld", b, k2);
      cyc(); @(negedge clk);
      chk("wrld_rdy", memRDY, 1'b1);
      chk("wrld_data", rdata, mem[b]);
    end
  endtask

  // read a, with a load of b during its bus phase; b follows without going ready
  task automatic do_b2b(input logic [15:0] a, input int k, input logic [15:0] b, input int k2);
    cyc(); ldMAR = 1'b1;
    cyc(); mar = a;
    @(negedge clk); chk("b2b_pend_rdy", memRDY, 1'b0);
    for (int i = 0; i <= k; i++) begin
      cyc();
      if (i == 0) ldMAR = 1'b1;
      if (i == 1) begin mar = b; cur_mar = b; end
      if (i == k) begin mem_ack = 1'b1; mem_rdata = rd_mem(a); end
      @(negedge clk);
      chk("b2b_req1", mem_req, 1'b1);
      chk("b2b_addr1", mem_addr, a);
    end
    cyc(); @(negedge clk);
    chk("b2b_gap_rdy", memRDY, 1'b0);
    chk("b2b_gap_req", mem_req, 1'b0);
    chk("b2b_data1", rdata, mem[a]);
    bus_read("b2b2", b, k2);
    cyc(); @(negedge clk);
    chk("b2b_done_rdy", memRDY, 1'b1);
    chk("b2b_data2", rdata, mem[b]);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdy"}, memRDY, 1'b1);
    chk({tag, "_req"}, mem_req, 1'b0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_addr, 16'h0);
    chk({tag, "_wdata"}, mem_wdata, 16'h0);
    chk({tag, "_rdata"}, rdata, 16'h0);
    chk({tag, "_berr"}, bus_err, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    logic [15:0] a, b;
    repeat (2) cyc();
    @(negedge clk); chk_reset_vals("rst0");
    cyc(); rst = 1'b1;

    // directed cases from the block's intended use
    do_read(16'h3000, 2);
    do_read(16'h4000, 0);
    do_write(16'hBEEF, 0, 1'b0, 16'h0, 0);
    do_b2b(16'h3000, 2, 16'h3001, 1);
    cur_mar = 16'h3001;
    do_write(16'h5A5A, 1, 1'b1, 16'h3001, 0);
    do_write(16'hC0DE, 2, 1'b1, 16'h3002, 3);

    // reset in the middle of a read, followed by a stale ack
    cyc(); ldMAR = 1'b1;
    cyc(); mar = 16'h5000;
    cyc(); @(negedge clk); chk("mid_req", mem_req, 1'b1);
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1;
    @(negedge clk); chk_reset_vals("rst1");
    cyc(); mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    @(negedge clk); chk("late_ack_req", mem_req, 1'b0);
    cyc(); @(negedge clk);
    chk("late_ack_rdata", rdata, 16'h0);
    chk("late_ack_rdy", memRDY, 1'b1);
    cur_mar = 16'h5000;

    // random traffic over a small address window so writes get read back
    for (int it = 0; it < 40; it++) begin
      a = 16'h3000 + 16'($urandom_range(0, 7));
      b = 16'h3000 + 16'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: do_read(a, $urandom_range(0, 3));
        1: do_write(16'($urandom), $urandom_range(0, 3), 1'b0, 16'h0, 0);
        2: do_b2b(a, $urandom_range(1, 3), b, $urandom_range(0, 3));
        default: do_write(16'($urandom), $urandom_range(0, 3), 1'b1, b, $urandom_range(0, 3));
      endcase
    end
    chk("berr_clean", bus_err, 1'b0);

    // unanswered read
    a = rdata;
    cyc(); ldMAR = 1'b1;
    cyc(); mar = 16'h6000;
    hi = 0;
`ifdef LC3_MEM_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      cyc(); @(negedge clk);
      if (mem_req) hi++;
    end
    chk("to_req_cycles", 16'(hi), 16'd4);
    cyc(); @(negedge clk);
    chk("to_req_drop", mem_req, 1'b0);
    chk("to_berr", bus_err, 1'b1);
    chk("to_rdata", rdata, 16'h0);
    chk("to_rdy", memRDY, 1'b1);
`else
    for (int i = 0; i < 100; i++) begin
      cyc(); @(negedge clk);
      if (mem_req) hi++;
    end
    chk("noto_req_cycles", 16'(hi), 16'd100);
    chk("noto_berr", bus_err, 1'b0);
    chk("noto_rdata", rdata, a);
    cyc(); mem_ack = 1'b1; mem_rdata = 16'h7777;
    cyc(); @(negedge clk);
    chk("noto_rdata_late", rdata, 16'h7777);
    chk("noto_rdy", memRDY, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
